write_combining_buffer: RTL

- Write-side counterpart to the line-based read path: accepts narrow DATA_W writes from a requester and merges them into a single LINES_W-wide line buffer.
- Pushes merged lines to external memory over a line-wide bus carrying a per-word valid mask.
- Sits between a word-granular write client and the external (DDR3) line interface, mirroring the read path's ext_* handshake in the write direction.

---
 rtl/write_combining_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/write_combining_buffer.sv
// Write-combining buffer: merges narrow client writes into one line-wide
// buffer and pushes complete or flushed lines to external memory together
// with a per-word valid mask.
module write_combining_buffer #(
  parameter  int LINES_W    = 128,
  parameter  int DATA_W     = 8,
  parameter  int EXT_ADDR_W = 26,
  localparam int WORDS      = LINES_W / DATA_W,
  localparam int OFF_W      = $clog2(WORDS),
  localparam int ADDR_W     = EXT_ADDR_W + OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_rq,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  flush_rq,
  output logic                  ext_write_rq,
  input  logic                  ext_rq_finished,
  output logic [EXT_ADDR_W-1:0] ext_address,
  output logic [LINES_W-1:0]    ext_data,
  output logic [WORDS-1:0]      ext_mask,
  output logic                  finished,
  output logic                  busy
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FLUSHING = 2'd2
  } state_t;

  state_t                r_state;
  logic [EXT_ADDR_W-1:0] r_tag;
  logic [LINES_W-1:0]    r_data;
  logic [WORDS-1:0]      r_mask;
  logic                  r_finished;
  logic                  r_ext_write_rq;
  logic                  r_flush_from_rq;
  logic                  r_pend_valid;
  logic [ADDR_W-1:0]     r_pend_addr;
  logic [DATA_W-1:0]     r_pend_data;

  logic [EXT_ADDR_W-1:0] w_tag;
  logic [OFF_W-1:0]      w_off;
  logic [WORDS-1:0]      w_bit;
  logic [WORDS-1:0]      w_merged_mask;
  logic                  w_full;
  logic [EXT_ADDR_W-1:0] w_pend_tag;
  logic [OFF_W-1:0]      w_pend_off;
  logic [WORDS-1:0]      w_pend_bit;

  // Decode the incoming request and the pending slot into tag/word/mask bit.
  assign w_tag         = address[ADDR_W-1:OFF_W];
  assign w_off         = address[OFF_W-1:0];
  assign w_bit         = {{(WORDS-1){1'b0}}, 1'b1} << w_off;
  assign w_merged_mask = r_mask | w_bit;
  assign w_full        = &w_merged_mask;
  assign w_pend_tag    = r_pend_addr[ADDR_W-1:OFF_W];
  assign w_pend_off    = r_pend_addr[OFF_W-1:0];
  assign w_pend_bit    = {{(WORDS-1){1'b0}}, 1'b1} << w_pend_off;

  assign ext_write_rq = r_ext_write_rq;
  assign ext_address  = r_tag;
  assign ext_data     = r_data;
  assign ext_mask     = r_mask;
  assign finished     = r_finished;
  assign busy         = (r_state == FLUSHING);

  // Buffer state machine: merge writes, start flushes, retire completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= EMPTY;
      r_tag           <= '0;
      r_data          <= '0;
      r_mask          <= '0;
      r_finished      <= 1'b0;
      r_ext_write_rq  <= 1'b0;
      r_flush_from_rq <= 1'b0;
      r_pend_valid    <= 1'b0;
      r_pend_addr     <= '0;
      r_pend_data     <= '0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        EMPTY: begin
          // A simultaneous flush_rq is dropped in favour of the write.
          if (write_rq) begin
            r_tag                         <= w_tag;
            r_data[w_off*DATA_W +: DATA_W] <= write_data;
            r_mask                        <= w_bit;
            r_finished                    <= 1'b1;
            r_state                       <= FILLING;
          end else if (flush_rq) begin
            r_finished <= 1'b1;
          end
        end
        FILLING: begin
          if (write_rq) begin
            if (w_tag == r_tag) begin
              r_data[w_off*DATA_W +: DATA_W] <= write_data;
              r_mask                        <= w_merged_mask;
              r_finished                    <= 1'b1;
              if (w_full) begin
                // Line complete: push it out, write already acknowledged.
                r_state         <= FLUSHING;
                r_ext_write_rq  <= 1'b1;
                r_flush_from_rq <= 1'b0;
              end
            end else begin
              // Different line: park the write until the current line is out.
              r_pend_valid    <= 1'b1;
              r_pend_addr     <= address;
              r_pend_data     <= write_data;
              r_state         <= FLUSHING;
              r_ext_write_rq  <= 1'b1;
              r_flush_from_rq <= 1'b0;
            end
          end else if (flush_rq) begin
            r_state         <= FLUSHING;
            r_ext_write_rq  <= 1'b1;
            r_flush_from_rq <= 1'b1;
          end
        end
        FLUSHING: begin
          if (ext_rq_finished) begin
            r_ext_write_rq <= 1'b0;
            r_mask         <= '0;
            if (r_pend_valid) begin
              r_tag                              <= w_pend_tag;
              r_data[w_pend_off*DATA_W +: DATA_W] <= r_pend_data;
              r_mask                             <= w_pend_bit;
              r_pend_valid                       <= 1'b0;
              r_finished                         <= 1'b1;
              r_state                            <= FILLING;
            end else begin
              r_finished <= r_flush_from_rq;
              r_state    <= EMPTY;
            end
            r_flush_from_rq <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

endmodule
